// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   OPCODE_BRANCH / OPCODE_JAL : RV32 major opcodes (instr[6:0])
//   INSTR_BYTES                : PC increment per fetched instruction
//   fetch_state_t              : fetch FSM encoding (RUN, HOLD, DRAIN)
package instr_fetch_queue_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam int         INSTR_BYTES   = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,   // requests permitted
        HOLD  = 2'd1,   // branch stall active, no requests
        DRAIN = 2'd2    // first cycle after a flush, responses discarded
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs for the fetch stage.
//   clk, reset    : clock, asynchronous active-high reset
//   push, wdata   : write wdata at the tail (dropped if full and not popping)
//   pop           : advance the head (ignored while empty)
//   flush         : empty the FIFO; wins over push and pop
//   rdata         : head entry (meaningful only while !empty)
//   count         : occupancy, 0..DEPTH
//   full, empty   : count==DEPTH, count==0
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only read
    // after it has been written, and empty gates the head outputs upstream.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, requests a 1-cycle-latency instruction memory and
// buffers responses in fetch_fifo for dispatch.
//   clk, reset                      : clock, asynchronous active-high reset
//   stall                           : branch stall, blocks new requests
//   imem_rd_en, imem_addr           : memory request (address = PC)
//   imem_data                       : response, valid the cycle after a request
//   cdb_branch, cdb_branch_taken,
//   cdb_branch_target               : taken branch flushes and redirects the PC
//   dispatch_ren                    : pop the head entry
//   instr, instr_pc                 : head entry (0 while empty)
//   instr_is_branch                 : head holds a conditional branch
//   empty, full                     : FIFO occupancy flags
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    output logic            imem_rd_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            cdb_branch,
    input  logic            cdb_branch_taken,
    input  logic [XLEN-1:0] cdb_branch_target,
    input  logic            dispatch_ren,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_is_branch,
    output logic            empty,
    output logic            full
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t        state;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     inflight_pc;
    logic                inflight;
    logic                flush;
    logic                push;
    logic [CW-1:0]       count;
    logic [2*XLEN-1:0]   head;

    assign flush = cdb_branch && cdb_branch_taken;

    // Slot reservation: an outstanding response counts as occupied, so every
    // response is guaranteed space and memory never sees backpressure. The
    // reset term keeps the request low while reset is held.
    assign imem_rd_en = !reset && (state == RUN) && !stall && !flush &&
                        (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
    assign imem_addr  = pc;

    // Responses are dropped in the flush cycle and in DRAIN (wrong-path data).
    assign push = inflight && !flush && (state != DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= PC_RESET;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                inflight_pc <= pc;
                pc          <= pc + XLEN'(INSTR_BYTES);
            end
            if (flush) begin
                pc    <= cdb_branch_target;
                state <= DRAIN;
            end else begin
                case (state)
                    RUN:     if (stall) state <= HOLD;
                    HOLD:    if (!stall) state <= RUN;
                    DRAIN:   state <= stall ? HOLD : RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (dispatch_ren),
        .flush (flush),
        .wdata ({inflight_pc, imem_data}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign instr           = empty ? '0 : head[XLEN-1:0];
    assign instr_pc        = empty ? '0 : head[2*XLEN-1:XLEN];
    assign instr_is_branch = !empty && (head[6:0] == OPCODE_BRANCH);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. Each table row gives the inputs for one
// cycle and the outputs expected in that cycle before the rising edge.
module tb_instr_fetch_queue;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        cdb_branch;
    logic        cdb_branch_taken;
    logic [31:0] cdb_branch_target;
    logic        dispatch_ren;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_branch;
    logic        empty;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_queue #(
        .DEPTH    (4),
        .XLEN     (32),
        .PC_RESET (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .imem_rd_en        (imem_rd_en),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .cdb_branch        (cdb_branch),
        .cdb_branch_taken  (cdb_branch_taken),
        .cdb_branch_target (cdb_branch_target),
        .dispatch_ren      (dispatch_ren),
        .instr             (instr),
        .instr_pc          (instr_pc),
        .instr_is_branch   (instr_is_branch),
        .empty             (empty),
        .full              (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: address-tagged word; the word at 0x10 carries a branch opcode.
    function automatic logic [31:0] word(input logic [31:0] addr);
        word = {addr[23:0], (addr == 32'h10) ? 8'h63 : 8'h00};
    endfunction

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        cb;
        logic        tk;
        logic [31:0] tgt;
        logic        ren;
        logic        rd;
        logic [31:0] addr;
        logic        emp;
        logic        ful;
        logic [31:0] ipc;
        logic        br;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic s, input logic cb, input logic tk,
                               input logic [31:0] tgt, input logic ren,
                               input logic rd, input logic [31:0] addr,
                               input logic emp, input logic ful,
                               input logic [31:0] ipc, input logic br);
        vec_t r;
        r.stall = s;  r.cb = cb;    r.tk = tk;   r.tgt = tgt; r.ren = ren;
        r.rd = rd;    r.addr = addr; r.emp = emp; r.ful = ful; r.ipc = ipc; r.br = br;
        return r;
    endfunction

    task automatic check_outputs(input string tag, input logic rd, input logic [31:0] addr,
                                 input logic emp, input logic ful,
                                 input logic [31:0] ipc, input logic br);
        check({tag, " imem_rd_en"}, 32'(imem_rd_en), 32'(rd));
        check({tag, " imem_addr"}, imem_addr, addr);
        check({tag, " empty"}, 32'(empty), 32'(emp));
        check({tag, " full"}, 32'(full), 32'(ful));
        check({tag, " instr_pc"}, instr_pc, ipc);
        check({tag, " instr"}, instr, emp ? 32'h0 : word(ipc));
        check({tag, " instr_is_branch"}, 32'(instr_is_branch), 32'(br));
    endtask

    initial begin
        //              stall cb tk tgt        ren | rd addr      emp ful ipc       br
        // fill from reset: 4 requests then stop at full
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   1, 32'h00,  1, 0, 32'h0,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   1, 32'h04,  1, 0, 32'h0,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   1, 32'h08,  0, 0, 32'h0,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   1, 32'h0C,  0, 0, 32'h0,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   0, 32'h10,  0, 0, 32'h0,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   0, 32'h10,  0, 1, 32'h0,   0));
        // pop every cycle: steady push+pop, heads in order
        vecs.push_back(v(0, 0, 0, 32'h0,   1,   0, 32'h10,  0, 1, 32'h0,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   1,   1, 32'h10,  0, 0, 32'h4,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   1,   1, 32'h14,  0, 0, 32'h8,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   1,   1, 32'h18,  0, 0, 32'hC,   0));
        // branch at head, then stall: PC frozen, issued request still lands
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   1, 32'h1C,  0, 0, 32'h10,  1));
        vecs.push_back(v(1, 0, 0, 32'h0,   0,   0, 32'h20,  0, 0, 32'h10,  1));
        vecs.push_back(v(1, 0, 0, 32'h0,   0,   0, 32'h20,  0, 1, 32'h10,  1));
        vecs.push_back(v(0, 0, 0, 32'h0,   1,   0, 32'h20,  0, 1, 32'h10,  1));
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   1, 32'h20,  0, 0, 32'h14,  0));
        // taken branch with count=3, inflight=1: flush, drain, redirect
        vecs.push_back(v(0, 1, 1, 32'h100, 0,   0, 32'h24,  0, 0, 32'h14,  0));
        vecs.push_back(v(0, 0, 0, 32'h0,   1,   0, 32'h100, 1, 0, 32'h0,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   1,   1, 32'h100, 1, 0, 32'h0,   0));
        vecs.push_back(v(0, 0, 0, 32'h0,   1,   1, 32'h104, 1, 0, 32'h0,   0));
        // not-taken branch during stall: contents kept, fetch resumes at held PC
        vecs.push_back(v(1, 1, 0, 32'h200, 0,   0, 32'h108, 0, 0, 32'h100, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   0, 32'h108, 0, 0, 32'h100, 0));
        vecs.push_back(v(0, 0, 0, 32'h0,   0,   1, 32'h108, 0, 0, 32'h100, 0));

        reset             = 1'b1;
        stall             = 1'b0;
        cdb_branch        = 1'b0;
        cdb_branch_taken  = 1'b0;
        cdb_branch_target = '0;
        dispatch_ren      = 1'b0;
        imem_data         = '0;

        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset", 0, 32'h0, 1, 0, 32'h0, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            stall             = vecs[i].stall;
            cdb_branch        = vecs[i].cb;
            cdb_branch_taken  = vecs[i].tk;
            cdb_branch_target = vecs[i].tgt;
            dispatch_ren      = vecs[i].ren;
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].emp,
                          vecs[i].ful, vecs[i].ipc, vecs[i].br);
            @(negedge clk);
        end

        // Mid-stream reset with count=2 and a response in flight.
        stall        = 1'b0;
        cdb_branch   = 1'b0;
        dispatch_ren = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_outputs("async_reset", 0, 32'h0, 1, 0, 32'h0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs("post_reset0", 1, 32'h0, 1, 0, 32'h0, 0);
        @(negedge clk);
        #1;
        check_outputs("post_reset1", 1, 32'h4, 1, 0, 32'h0, 0);
        @(negedge clk);
        #1;
        check_outputs("post_reset2", 1, 32'h8, 0, 0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
